// File: rtl/store_narrow_rmw_if.sv
// Store request / word-memory bundle for the store narrowing unit.
// The unit itself connects through the slave modport, and the requester/memory side connects through the master modport.
interface store_narrow_rmw_if #(
    parameter int ADDR_W = 32
);
    logic              req_valid;
    logic              req_ready;
    logic [1:0]        req_size;
    logic [ADDR_W-1:0] req_addr;
    logic [31:0]       req_data;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_rd_en;
    logic [31:0]       mem_rdata;
    logic              mem_wr_en;
    logic [31:0]       mem_wdata;
    logic              done;
    logic              misaligned;

    modport slave (
        input  req_valid,
        input  req_size,
        input  req_addr,
        input  req_data,
        input  mem_rdata,
        output req_ready,
        output mem_addr,
        output mem_rd_en,
        output mem_wr_en,
        output mem_wdata,
        output done,
        output misaligned
    );

    modport master (
        output req_valid,
        output req_size,
        output req_addr,
        output req_data,
        output mem_rdata,
        input  req_ready,
        input  mem_addr,
        input  mem_rd_en,
        input  mem_wr_en,
        input  mem_wdata,
        input  done,
        input  misaligned
    );
endinterface

// File: rtl/store_narrow_rmw.sv
// Narrows sb/sh/sw register values into a word-wide memory.
// Sub-word stores use a read-modify-write sequence, and word stores write directly.
module store_narrow_rmw #(
    parameter int ADDR_W = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    store_narrow_rmw_if.slave    bus
);

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_RD   = 3'd1,
        ST_CAP  = 3'd2,
        ST_WR   = 3'd3,
        ST_DONE = 3'd4
    } state_e;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] addr_q,  addr_d;
    logic [1:0]        off_q,   off_d;
    logic [1:0]        size_q,  size_d;
    logic [15:0]       data_q,  data_d;
    logic [31:0]       wdata_q, wdata_d;
    logic              mis_q,   mis_d;
    logic              accept_s;

    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] off);
        logic bad;
        case (size)
            SZ_BYTE: bad = 1'b0;
            SZ_HALF: bad = off[0];
            SZ_WORD: bad = (off != 2'b00);
            default: bad = 1'b1;
        endcase
        return bad;
    endfunction

    // Little-endian lane insert of the narrow value into the old word.
    function automatic logic [31:0] merge_word(input logic [31:0] old,
                                               input logic [15:0] data,
                                               input logic [1:0]  size,
                                               input logic [1:0]  off);
        logic [31:0] res;
        res = old;
        case (size)
            SZ_BYTE: begin
                case (off)
                    2'd0:    res[7:0]   = data[7:0];
                    2'd1:    res[15:8]  = data[7:0];
                    2'd2:    res[23:16] = data[7:0];
                    2'd3:    res[31:24] = data[7:0];
                    default: res = old;
                endcase
            end
            SZ_HALF: begin
                if (off[1]) begin
                    res[31:16] = data;
                end else begin
                    res[15:0] = data;
                end
            end
            default: res = old;
        endcase
        return res;
    endfunction

    assign accept_s = bus.req_valid && (state_q == ST_IDLE);

    // Next-state and latch update logic.
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        off_d   = off_q;
        size_d  = size_q;
        data_d  = data_q;
        wdata_d = wdata_q;
        mis_d   = mis_q;
        case (state_q)
            ST_IDLE: begin
                if (accept_s) begin
                    addr_d = {bus.req_addr[ADDR_W-1:2], 2'b00};
                    off_d  = bus.req_addr[1:0];
                    size_d = bus.req_size;
                    data_d = bus.req_data[15:0];
                    mis_d  = is_misaligned(bus.req_size, bus.req_addr[1:0]);
                    if (is_misaligned(bus.req_size, bus.req_addr[1:0])) begin
                        state_d = ST_DONE;
                    end else if (bus.req_size == SZ_WORD) begin
                        wdata_d = bus.req_data;
                        state_d = ST_WR;
                    end else begin
                        state_d = ST_RD;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RD: begin
                state_d = ST_CAP;
            end
            ST_CAP: begin
                wdata_d = merge_word(bus.mem_rdata, data_q, size_q, off_q);
                state_d = ST_WR;
            end
            ST_WR: begin
                state_d = ST_DONE;
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and latch registers; reset aborts any store in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            addr_q  <= {ADDR_W{1'b0}};
            off_q   <= 2'b00;
            size_q  <= 2'b00;
            data_q  <= 16'h0000;
            wdata_q <= 32'h0000_0000;
            mis_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            off_q   <= off_d;
            size_q  <= size_d;
            data_q  <= data_d;
            wdata_q <= wdata_d;
            mis_q   <= mis_d;
        end
    end

    assign bus.req_ready  = (state_q == ST_IDLE);
    assign bus.mem_rd_en  = (state_q == ST_RD);
    assign bus.mem_wr_en  = (state_q == ST_WR);
    assign bus.done       = (state_q == ST_DONE);
    assign bus.misaligned = mis_q && (state_q == ST_DONE);
    assign bus.mem_addr   = addr_q;
    assign bus.mem_wdata  = wdata_q;

endmodule

// File: tb/tb_store_narrow_rmw.sv
// Directed, table-driven bench for store_narrow_rmw with a 1-cycle-latency word memory model.
module tb_store_narrow_rmw;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   total = 0;
    int   bad = 0;
    int   cyc = 0;

    store_narrow_rmw_if #(.ADDR_W(32)) bus ();

    store_narrow_rmw #(.ADDR_W(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    logic [31:0] mem [0:255];
    logic [31:0] rdata_r = 32'h0;
    logic        pl_en = 1'b0;
    logic [7:0]  pl_idx = 8'h0;
    logic [31:0] pl_val = 32'h0;

    always @(posedge clk) begin
        if (pl_en) mem[pl_idx] <= pl_val;
        if (bus.mem_wr_en) mem[bus.mem_addr[9:2]] <= bus.mem_wdata;
        if (bus.mem_rd_en) rdata_r <= mem[bus.mem_addr[9:2]];
    end
    assign bus.mem_rdata = rdata_r;

    typedef struct {
        logic [1:0]  sz;
        logic [31:0] addr;
        logic [31:0] data;
        logic [31:0] init;
        int          e_rd;
        int          e_wr;
        int          e_done;
        logic [31:0] e_wdata;
        logic        e_mis;
        logic [31:0] e_mem;
    } vec_t;

    vec_t vt [9];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
        end
    endtask

    task automatic preload(input logic [31:0] a, input logic [31:0] v);
        @(negedge clk);
        pl_en = 1'b1; pl_idx = a[9:2]; pl_val = v;
        @(posedge clk); #1;
        pl_en = 1'b0;
    endtask

    task automatic run_req(input int id, input logic [1:0] sz, input logic [31:0] a,
                           input logic [31:0] d, input int e_rd, input int e_wr,
                           input int e_done, input logic [31:0] e_wdata, input logic e_mis);
        int rd_c = -1, wr_c = -1, done_c = -1, rd_n = 0, wr_n = 0, done_n = 0, stray_mis = 0;
        logic [31:0] wd = 32'h0, rd_a = 32'h0, wr_a = 32'h0;
        logic mis_v = 1'b0, rdy_after = 1'b0;
        @(negedge clk);
        chk($sformatf("v%0d ready_before", id), {31'd0, bus.req_ready}, 32'd1);
        bus.req_valid = 1'b1; bus.req_size = sz; bus.req_addr = a; bus.req_data = d;
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        for (int k = 1; k <= 6; k++) begin
            if (bus.mem_rd_en) begin rd_n++; if (rd_c < 0) rd_c = k; rd_a = bus.mem_addr; end
            if (bus.mem_wr_en) begin wr_n++; if (wr_c < 0) wr_c = k; wd = bus.mem_wdata; wr_a = bus.mem_addr; end
            if (bus.done) begin done_n++; if (done_c < 0) done_c = k; mis_v = bus.misaligned; end
            if (bus.misaligned && !bus.done) stray_mis++;
            if (done_c >= 0 && k == done_c + 1) rdy_after = bus.req_ready;
            @(posedge clk); #1;
        end
        chk($sformatf("v%0d rd_cycle", id), rd_c, e_rd);
        chk($sformatf("v%0d wr_cycle", id), wr_c, e_wr);
        chk($sformatf("v%0d done_cycle", id), done_c, e_done);
        chk($sformatf("v%0d rd_count", id), rd_n, (e_rd < 0) ? 0 : 1);
        chk($sformatf("v%0d wr_count", id), wr_n, (e_wr < 0) ? 0 : 1);
        chk($sformatf("v%0d done_count", id), done_n, 1);
        chk($sformatf("v%0d misaligned", id), {31'd0, mis_v}, {31'd0, e_mis});
        chk($sformatf("v%0d stray_mis", id), stray_mis, 0);
        chk($sformatf("v%0d ready_after", id), {31'd0, rdy_after}, 32'd1);
        if (e_wr > 0) begin
            chk($sformatf("v%0d wdata", id), wd, e_wdata);
            chk($sformatf("v%0d wr_addr", id), wr_a, {a[31:2], 2'b00});
        end
        if (e_rd > 0) chk($sformatf("v%0d rd_addr", id), rd_a, {a[31:2], 2'b00});
    endtask

    initial begin
        int acc [4];
        int n;
        int wr_seen;
        logic [31:0] tmp;

        bus.req_valid = 1'b0; bus.req_size = 2'b00; bus.req_addr = 32'h0; bus.req_data = 32'h0;
        for (int i = 0; i < 256; i++) mem[i] = 32'h0;

        vt[0] = '{2'b00, 32'h102, 32'h12345678, 32'hAABBCCDD, 1, 3, 4, 32'hAA78CCDD, 1'b0, 32'hAA78CCDD};
        vt[1] = '{2'b01, 32'h102, 32'hFFFFBEEF, 32'hAABBCCDD, 1, 3, 4, 32'hBEEFCCDD, 1'b0, 32'hBEEFCCDD};
        vt[2] = '{2'b01, 32'h100, 32'hFFFFBEEF, 32'hAABBCCDD, 1, 3, 4, 32'hAABBBEEF, 1'b0, 32'hAABBBEEF};
        vt[3] = '{2'b10, 32'h104, 32'hDEADBEEF, 32'h00000000, -1, 1, 2, 32'hDEADBEEF, 1'b0, 32'hDEADBEEF};
        vt[4] = '{2'b01, 32'h101, 32'h0000BEEF, 32'h11111111, -1, -1, 1, 32'h0, 1'b1, 32'h11111111};
        vt[5] = '{2'b10, 32'h106, 32'hDEADBEEF, 32'h22222222, -1, -1, 1, 32'h0, 1'b1, 32'h22222222};
        vt[6] = '{2'b11, 32'h100, 32'hDEADBEEF, 32'h33333333, -1, -1, 1, 32'h0, 1'b1, 32'h33333333};
        vt[7] = '{2'b00, 32'h101, 32'h0000005A, 32'hAABBCCDD, 1, 3, 4, 32'hAABB5ADD, 1'b0, 32'hAABB5ADD};
        vt[8] = '{2'b00, 32'h103, 32'hFFFFFFC3, 32'h00000000, 1, 3, 4, 32'hC3000000, 1'b0, 32'hC3000000};

        // Reset state
        #12;
        chk("rst ready", {31'd0, bus.req_ready}, 32'd1);
        chk("rst strobes", {29'd0, bus.mem_rd_en, bus.mem_wr_en, bus.done}, 32'd0);
        chk("rst misaligned", {31'd0, bus.misaligned}, 32'd0);
        chk("rst mem_addr", bus.mem_addr, 32'h0);
        chk("rst mem_wdata", bus.mem_wdata, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 9; i++) begin
            preload(vt[i].addr, vt[i].init);
            run_req(i, vt[i].sz, vt[i].addr, vt[i].data, vt[i].e_rd, vt[i].e_wr,
                    vt[i].e_done, vt[i].e_wdata, vt[i].e_mis);
            tmp = vt[i].addr;
            chk($sformatf("v%0d mem_word", i), mem[tmp[9:2]], vt[i].e_mem);
        end

        // Back-to-back byte stores with req_valid held high
        preload(32'h0, 32'h0);
        @(negedge clk);
        bus.req_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            bus.req_size = 2'b00;
            bus.req_addr = i;
            bus.req_data = 32'hFFFFFF00 | ((i + 1) * 32'h11);
            n = 0;
            while (!bus.req_ready && n < 20) begin
                @(negedge clk);
                n++;
            end
            total++;
            if (n >= 20) begin
                bad++;
                $display("FAIL b2b accept_timeout: got no accept expected accept of request %0d", i);
            end
            acc[i] = cyc;
            @(posedge clk);
            @(negedge clk);
        end
        bus.req_valid = 1'b0;
        repeat (6) @(negedge clk);
        for (int i = 1; i < 4; i++) chk($sformatf("b2b spacing%0d", i), acc[i] - acc[i-1], 5);
        chk("b2b final_word", mem[0], 32'h44332211);

        // Reset during CAP of a byte store
        preload(32'h108, 32'h01020304);
        @(negedge clk);
        bus.req_valid = 1'b1; bus.req_size = 2'b00; bus.req_addr = 32'h108; bus.req_data = 32'h000000EE;
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        chk("midrst ready", {31'd0, bus.req_ready}, 32'd1);
        chk("midrst strobes", {28'd0, bus.mem_rd_en, bus.mem_wr_en, bus.done, bus.misaligned}, 32'd0);
        chk("midrst mem_addr", bus.mem_addr, 32'h0);
        chk("midrst mem_wdata", bus.mem_wdata, 32'h0);
        wr_seen = 0;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            if (bus.mem_wr_en) wr_seen++;
        end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("midrst release_ready", {31'd0, bus.req_ready}, 32'd1);
        chk("midrst release_strobes", {28'd0, bus.mem_rd_en, bus.mem_wr_en, bus.done, bus.misaligned}, 32'd0);
        for (int k = 0; k < 4; k++) begin
            @(posedge clk); #1;
            if (bus.mem_wr_en) wr_seen++;
        end
        chk("midrst no_write", wr_seen, 0);
        chk("midrst mem_unchanged", mem[8'h42], 32'h01020304);
        run_req(100, 2'b10, 32'h10C, 32'hCAFEF00D, -1, 1, 2, 32'hCAFEF00D, 1'b0);
        chk("post_rst sw mem", mem[8'h43], 32'hCAFEF00D);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/store_narrow_rmw.md
# store_narrow_rmw

Store-side narrowing unit for the Mini-MIPS data path. It performs the inverse of load sign extension: it takes a 32-bit register value and an `sb`/`sh`/`sw` size, and narrows and lane-aligns the value into a word-wide data memory. Byte and halfword stores use a read-modify-write sequence. It sits between the execute stage's store request and the word-addressed data memory port.

## Interface
- `ADDR_W`, default 32: byte-address width of requests and of the memory address.
- `clk`  in  1: single clock; all state updates on rising edge.
- `rst_n`  in  1: asynchronous, active-low reset.
- `req_valid`  in  1: store request present.
- `req_ready`  out  1: high only in IDLE; a request is accepted on a cycle with `req_valid && req_ready`.
- `req_size`  in  2: 00 byte, 01 halfword, 10 word, 11 reserved.
- `req_addr`  in  ADDR_W: byte address.
- `req_data`  in  32: register value; only the low 8 or 16 bits are used for byte or halfword stores.
- `mem_addr`  out  ADDR_W: latched word address, `{req_addr[ADDR_W-1:2], 2'b00}`.
- `mem_rd_en`  out  1: one-cycle read strobe.
- `mem_rdata`  in  32: read data, valid in the cycle after `mem_rd_en` (fixed latency 1).
- `mem_wr_en`  out  1: one-cycle write strobe.
- `mem_wdata`  out  32: full merged word; meaningful only while `mem_wr_en` is high.
- `done`  out  1: one-cycle completion pulse.
- `misaligned`  out  1: asserted only together with `done`, for rejected requests.

## Operation
- States: IDLE, RD, CAP, WR, DONE. Outputs are Moore-decoded from the state and the latched registers.
  - `req_ready` = (state == IDLE).
  - `mem_rd_en` = (state == RD).
  - `mem_wr_en` = (state == WR).
  - `done` = (state == DONE).
- On accept, latch addr, size and data.
- Transitions out of IDLE on accept:
  - Misaligned request → DONE with `misaligned` set. Misaligned means: halfword with `addr[0]` = 1, word with `addr[1:0]` ≠ 0, or size 11. No memory access is made.
  - Word store → WR.
  - Byte or halfword store → RD.
- Remaining transitions: RD → CAP → WR → DONE → IDLE, unconditional.
- CAP: register `mem_rdata` at the end of the cycle as `old`.
- Merge rules (little-endian lanes):
  - Byte store: lane k = `addr[1:0]`. `wdata` = `old` with bits [8k+7:8k] replaced by `data[7:0]`.
  - Halfword store: h = `addr[1]`. `wdata` = `old` with bits [16h+15:16h] replaced by `data[15:0]`.
  - Word store: `wdata` = `data`; no read is issued.
- `mem_addr` holds the latched word address from the cycle after accept until the next accept.
- `req_valid` while `req_ready` is low is ignored, and inputs are not sampled.
- `misaligned` is cleared on every accept.

## Timing
- Accept in cycle T. Then:
  - Word store: `mem_wr_en` in T+1, `done` in T+2.
  - Byte or halfword store: `mem_rd_en` in T+1, `mem_rdata` sampled in T+2, `mem_wr_en` in T+3, `done` in T+4.
  - Misaligned: `done` and `misaligned` in T+1, no `mem_rd_en` or `mem_wr_en`.
- The next accept is possible in the cycle after DONE. Minimum spacing between accepts: 3 cycles for a word store, 5 for a byte or halfword store, 2 for a misaligned request.
- Exactly one `mem_wr_en` pulse per aligned request. Never more than one read per request.
- Reset (`rst_n` low, asynchronous):
  - state = IDLE, so `req_ready` = 1.
  - `mem_rd_en`, `mem_wr_en`, `done`, `misaligned` = 0.
  - `mem_addr`, `mem_wdata` and the internal latches = 0.
- Reset mid-operation aborts the store immediately. No write is issued after reset asserts, and any in-flight `mem_rd_en` or `mem_wr_en` drops asynchronously.

## Test plan
- **Byte store:** memory word at 0x100 = 0xAABBCCDD; `sb` with `req_addr` 0x102, `req_data` 0x12345678 → `mem_rd_en` at T+1 with `mem_addr` 0x100; `mem_wr_en` at T+3 with `mem_wdata` 0xAA78CCDD; `done` at T+4, `misaligned` 0.
- **Halfword store:** same memory; `sh` with `req_addr` 0x102, `req_data` 0xFFFFBEEF → `mem_wdata` 0xBEEFCCDD. Repeat at `req_addr` 0x100 → `mem_wdata` 0xAABBBEEF.
- **Word store:** `sw` with `req_addr` 0x104, `req_data` 0xDEADBEEF → no `mem_rd_en`; `mem_wr_en` at T+1 with `mem_addr` 0x104 and `mem_wdata` 0xDEADBEEF; `done` at T+2.
- **Misaligned requests:** `sh` at 0x101, `sw` at 0x106, and size 11 at 0x100 → each gives `done` and `misaligned` at T+1, zero memory strobes, and `req_ready` back high at T+2.
- **Back-to-back and ignored valid:** hold `req_valid` high with four queued `sb` requests to lanes 0–3 of 0x00000000 with data 0x11, 0x22, 0x33, 0x44, with the bench memory updating on each write → final word 0x44332211; accepts exactly 5 cycles apart.
- **Reset mid-operation:** assert `rst_n` low during CAP of an `sb` → `mem_wr_en` never asserts and memory is unchanged. On release, `req_ready` = 1 with all other outputs 0, and a following `sw` completes normally.
